// File: rtl/nios_fprint_shared_memory_scanner.sv
// Avalon-MM master that streams a window of shared memory, folds it into a
// rotate-xor fingerprint and writes the result back to a destination word.
module nios_fprint_shared_memory_scanner #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       word_count,
    input  logic [ADDR_W-1:0]     dest_addr,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     fingerprint,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_chipselect,
    output logic                  avm_write,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    output logic [DATA_W-1:0]     avm_writedata,
    input  logic [DATA_W-1:0]     avm_readdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int LAT_W = 2;
    localparam logic [BE_W-1:0] BE_ALL = {BE_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t                  state_q;
    logic [ADDR_W:0]         remain_q;
    logic [ADDR_W-1:0]       dest_q;
    logic [LAT_W-1:0]        lat_cnt_q;
    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_W-1:0]       acc_q;
    logic                    busy_q;
    logic                    done_q;
    logic [DATA_W-1:0]       fingerprint_q;
    logic [ADDR_W-1:0]       address_q;
    logic                    chipselect_q;
    logic                    write_q;
    logic [BE_W-1:0]         byteenable_q;
    logic [DATA_W-1:0]       writedata_q;

    logic [READ_LATENCY:0]   vld_shift;
    logic [READ_LATENCY-1:0] vld_d;
    logic [DATA_W-1:0]       acc_d;

    // Every READ cycle issues exactly one read; the shift register marks the
    // cycle in which that read's data is present on avm_readdata.
    always_comb begin
        vld_shift = {vld_q, state_q == ST_READ};
        vld_d     = vld_shift[READ_LATENCY-1:0];
        acc_d     = acc_q;
        if (vld_q[READ_LATENCY-1]) begin
            acc_d = {acc_q[DATA_W-2:0], acc_q[DATA_W-1]} ^ avm_readdata;
        end
    end

    // NOTE: every register sits in the async-reset branch, so a reset mid-scan
    // drops the bus outputs in the same instant without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            remain_q      <= '0;
            dest_q        <= '0;
            lat_cnt_q     <= '0;
            vld_q         <= '0;
            acc_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fingerprint_q <= '0;
            address_q     <= '0;
            chipselect_q  <= 1'b0;
            write_q       <= 1'b0;
            byteenable_q  <= '0;
            writedata_q   <= '0;
        end else begin
            vld_q  <= vld_d;
            acc_q  <= acc_d;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        dest_q       <= dest_addr;
                        acc_q        <= '0;
                        busy_q       <= 1'b1;
                        chipselect_q <= 1'b1;
                        byteenable_q <= BE_ALL;
                        if (word_count == '0) begin
                            state_q     <= ST_WRITE;
                            address_q   <= dest_addr;
                            write_q     <= 1'b1;
                            writedata_q <= '0;
                        end else begin
                            state_q   <= ST_READ;
                            address_q <= base_addr;
                            remain_q  <= word_count - (ADDR_W+1)'(1);
                        end
                    end
                end
                ST_READ: begin
                    if (remain_q == '0) begin
                        state_q      <= ST_DRAIN;
                        lat_cnt_q    <= LAT_W'(READ_LATENCY - 1);
                        address_q    <= '0;
                        chipselect_q <= 1'b0;
                        byteenable_q <= '0;
                    end else begin
                        address_q <= address_q + ADDR_W'(1);
                        remain_q  <= remain_q - (ADDR_W+1)'(1);
                    end
                end
                ST_DRAIN: begin
                    // The last word arrives on this edge, so write acc_d, not acc_q.
                    if (lat_cnt_q == '0) begin
                        state_q      <= ST_WRITE;
                        address_q    <= dest_q;
                        chipselect_q <= 1'b1;
                        write_q      <= 1'b1;
                        byteenable_q <= BE_ALL;
                        writedata_q  <= acc_d;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - LAT_W'(1);
                    end
                end
                ST_WRITE: begin
                    state_q       <= ST_DONE;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b1;
                    fingerprint_q <= acc_q;
                    address_q     <= '0;
                    chipselect_q  <= 1'b0;
                    write_q       <= 1'b0;
                    byteenable_q  <= '0;
                    writedata_q   <= '0;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign fingerprint    = fingerprint_q;
    assign avm_address    = address_q;
    assign avm_chipselect = chipselect_q;
    assign avm_write      = write_q;
    assign avm_byteenable = byteenable_q;
    assign avm_writedata  = writedata_q;

endmodule

// File: tb/tb_nios_fprint_shared_memory_scanner.sv
// Directed bench: a latency-1 RAM model answers the scanner, and every cycle
// of each scan is compared against the expected bus/status pattern.
module tb_nios_fprint_shared_memory_scanner;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int L  = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic [AW-1:0] dest_addr = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] fingerprint;
    logic [AW-1:0] avm_address;
    logic          avm_chipselect;
    logic          avm_write;
    logic [3:0]    avm_byteenable;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata = '0;

    logic [DW-1:0] mem [256];
    int            wr_count = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] last_fp = '0;

    nios_fprint_shared_memory_scanner #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(L)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .base_addr(base_addr), .word_count(word_count), .dest_addr(dest_addr),
        .busy(busy), .done(done), .fingerprint(fingerprint),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write(avm_write), .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    // Shared-memory slave with one cycle of read latency.
    always @(posedge clk) begin
        if (avm_chipselect && !avm_write) avm_readdata <= mem[avm_address];
        if (avm_chipselect && avm_write) begin
            mem[avm_address] <= avm_writedata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_fp(input logic [AW-1:0] base, input int n);
        logic [DW-1:0] a = '0;
        logic [AW-1:0] ad;
        for (int i = 0; i < n; i++) begin
            ad = base + AW'(i);
            a  = {a[DW-2:0], a[DW-1]} ^ mem[ad];
        end
        return a;
    endfunction

    function automatic logic [47:0] observed();
        return {busy, done, avm_chipselect, avm_write, avm_byteenable,
                avm_chipselect ? avm_address : 8'h00, avm_writedata};
    endfunction

    // Starts a scan and checks cycles 1..wc+2 where wc is the WRITE cycle.
    task automatic run_scan(input string name, input logic [AW-1:0] base, input int n,
                            input logic [AW-1:0] dest, input bit glitch,
                            input logic [DW-1:0] exp_fp);
        int            wc;
        bit            rd, wr, ecs;
        logic [47:0]   e;
        wc = (n == 0) ? 1 : n + L + 1;
        base_addr  = base;
        word_count = (AW+1)'(n);
        dest_addr  = dest;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        base_addr  = ~base;
        word_count = 9'd7;
        dest_addr  = ~dest;
        check({name, " fp_hold"}, fingerprint, last_fp);
        for (int c = 1; c <= wc + 2; c++) begin
            rd  = (n > 0) && (c <= n);
            wr  = (c == wc);
            ecs = rd || wr;
            e = {c <= wc, c == wc + 1, ecs, wr, ecs ? 4'hF : 4'h0,
                 rd ? AW'(int'(base) + c - 1) : (wr ? dest : 8'h00),
                 wr ? exp_fp : 32'h0};
            check($sformatf("%s cyc%0d", name, c), observed(), e);
            if (c == wc + 1) begin
                check({name, " fp"}, fingerprint, exp_fp);
                check({name, " mem_dest"}, mem[dest], exp_fp);
            end
            if (glitch && (c == 2 || c == wc + 1)) begin
                start      = 1'b1;
                base_addr  = base + 8'h40;
                word_count = 9'd2;
                dest_addr  = dest + 8'h01;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start   = 1'b0;
        last_fp = exp_fp;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] exp;
        int            wr_before;
        for (int i = 0; i < 256; i++) mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;

        repeat (3) @(posedge clk);
        #1;
        check("reset outs", {observed(), fingerprint}, 80'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle outs", {observed(), fingerprint}, 80'h0);

        mem[8'h10] = 32'd1; mem[8'h11] = 32'd2; mem[8'h12] = 32'd3;
        run_scan("t1", 8'h10, 3, 8'h20, 1'b0, 32'h0000_0003);

        mem[8'h40] = 32'h8000_0000; mem[8'h41] = 32'h0;
        run_scan("t2", 8'h40, 2, 8'h22, 1'b0, 32'h0000_0001);

        exp = model_fp(8'hFE, 4);
        run_scan("t3 wrap", 8'hFE, 4, 8'h24, 1'b0, exp);

        run_scan("t4 n0", 8'h00, 0, 8'h05, 1'b0, 32'h0);

        exp = model_fp(8'h50, 5);
        run_scan("t5 restart", 8'h50, 5, 8'h70, 1'b1, exp);

        exp = model_fp(8'h80, 256);
        run_scan("full", 8'h80, 256, 8'h90, 1'b0, exp);

        // Reset during the second read cycle of an 8-word scan.
        mem[8'h60] = 32'hDEAD_BEEF;
        base_addr  = 8'h30;
        word_count = 9'd8;
        dest_addr  = 8'h60;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        wr_before = wr_count;
        reset_n = 1'b0;
        #1;
        check("t6 async", {observed(), fingerprint}, 80'h0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("t6 no_write", 32'(wr_count), 32'(wr_before));
        check("t6 mem", mem[8'h60], 32'hDEAD_BEEF);
        check("t6 idle", {observed(), fingerprint}, 80'h0);
        last_fp = '0;
        exp = model_fp(8'h30, 8);
        run_scan("t6 clean", 8'h30, 8, 8'h60, 1'b0, exp);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
